// File: rtl/udp_tx_frame_fifo.sv
// Store-and-forward byte FIFO for one slot of the UDP reply bus.
// A frame becomes visible to the reader only after its eof byte has been written.
//
// state     | meaning
// S_IDLE    | no committed frame, read outputs idle
// S_LOAD    | RAM read of rd_ptr issued, byte lands in obuf next cycle
// S_PRESENT | obuf holds a valid byte, offered while the slot is selected
module udp_tx_frame_fifo #(
    parameter logic [5:0] FifoAddr  = 6'd0,
    parameter int         AddrWidth = 11,
    parameter int         CntWidth  = 4
) (
    input  logic                udp_tx_rd_clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    input  logic                wr_eof,
    output logic                wr_dst_rdy_n,
    input  logic [5:0]          rd_fifo_addr,
    output logic                rd_sof_n,
    output logic [7:0]          rd_data_out,
    output logic                rd_eof_n,
    output logic                rd_src_rdy_n,
    input  logic                rd_dst_rdy_n,
    output logic [3:0]          fifo_status,
    output logic                overflow,
    output logic [CntWidth-1:0] frame_cnt
);
    localparam int Depth = 2 ** AddrWidth;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PRESENT} rd_state_e;
    rd_state_e state_q, state_d;

    logic [8:0]           mem_q [Depth];
    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0] commit_ptr_q, commit_ptr_d;
    logic [AddrWidth-1:0] rd_ptr_q;
    logic [AddrWidth-1:0] occupancy;
    logic [CntWidth-1:0]  frame_cnt_q, frame_cnt_d;
    logic                 discard_q, discard_d;
    logic                 overflow_q;
    logic [8:0]           obuf_q;
    logic                 first_q;
    logic                 valid, selected, full, cnt_max;
    logic                 wr_accept, wr_drop, xfer, eof_xfer, rd_fetch;

    assign valid     = (state_q == S_PRESENT);
    assign selected  = (rd_fifo_addr == FifoAddr);
    // rd_ptr runs one ahead of obuf, so a presented byte still counts as occupied
    assign occupancy = wr_ptr_q - rd_ptr_q + AddrWidth'(valid);
    assign full      = (occupancy == AddrWidth'(Depth - 1));
    assign cnt_max   = &frame_cnt_q;
    assign wr_accept = wr_en && !discard_q && !full && !cnt_max;
    assign wr_drop   = wr_en && !discard_q && (full || cnt_max);
    assign xfer      = valid && selected && !rd_dst_rdy_n;
    assign eof_xfer  = xfer && obuf_q[8];
    assign rd_fetch  = (state_q == S_LOAD) || (xfer && !obuf_q[8]);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        discard_d    = discard_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_eof) begin
                commit_ptr_d = wr_ptr_q + 1'b1;
            end
        end else if (wr_drop) begin
            wr_ptr_d  = commit_ptr_q;
            // a dropped eof byte already ends the frame; nothing left to discard
            discard_d = !wr_eof;
        end else if (wr_en && discard_q && wr_eof) begin
            discard_d = 1'b0;
        end
        frame_cnt_d = frame_cnt_q + CntWidth'(wr_accept && wr_eof) - CntWidth'(eof_xfer);
    end

    always_ff @(posedge udp_tx_rd_clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= {wr_eof, wr_data};
        end
    end

    always_ff @(posedge udp_tx_rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            frame_cnt_q  <= '0;
            discard_q    <= 1'b0;
            overflow_q   <= 1'b0;
            obuf_q       <= '0;
            first_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            frame_cnt_q  <= frame_cnt_d;
            discard_q    <= discard_d;
            overflow_q   <= wr_drop;
            if (rd_fetch) begin
                obuf_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (state_q == S_LOAD) begin
                first_q <= 1'b1;
            end else if (xfer) begin
                first_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge udp_tx_rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (frame_cnt_q != '0) state_d = S_LOAD;
            S_LOAD:    state_d = S_PRESENT;
            S_PRESENT: if (eof_xfer) state_d = (frame_cnt_d != '0) ? S_LOAD : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_src_rdy_n = 1'b1;
        rd_sof_n     = 1'b1;
        rd_eof_n     = 1'b1;
        rd_data_out  = '0;
        if (valid && selected) begin
            rd_src_rdy_n = 1'b0;
            rd_sof_n     = !first_q;
            rd_eof_n     = !obuf_q[8];
            rd_data_out  = obuf_q[7:0];
        end
    end

    assign wr_dst_rdy_n = full || cnt_max;
    assign fifo_status  = occupancy[AddrWidth-1 -: 4];
    assign overflow     = overflow_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_udp_tx_frame_fifo.sv
// Directed bench for udp_tx_frame_fifo: a default-size instance plus a
// 16-byte / 3-frame instance for overflow, frame-limit and wrap cases.
module tb_udp_tx_frame_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n;
    logic       wr_en_a, wr_en_b, wr_eof;
    logic [7:0] wr_data;
    logic [5:0] rd_addr;
    logic       rd_dst_rdy_n;
    logic       use_b;

    logic       a_wr_rdy_n, a_sof_n, a_eof_n, a_src_rdy_n, a_ovf;
    logic [7:0] a_data;
    logic [3:0] a_status, a_cnt;
    logic       b_wr_rdy_n, b_sof_n, b_eof_n, b_src_rdy_n, b_ovf;
    logic [7:0] b_data;
    logic [3:0] b_status;
    logic [1:0] b_cnt;

    logic       o_wr_rdy_n, o_sof_n, o_eof_n, o_src_rdy_n, o_ovf;
    logic [7:0] o_data;
    logic [3:0] o_status, o_cnt;

    udp_tx_frame_fifo u_dut_a (
        .udp_tx_rd_clk(clk), .reset_n(rst_a_n),
        .wr_en(wr_en_a), .wr_data(wr_data), .wr_eof(wr_eof), .wr_dst_rdy_n(a_wr_rdy_n),
        .rd_fifo_addr(rd_addr), .rd_sof_n(a_sof_n), .rd_data_out(a_data), .rd_eof_n(a_eof_n),
        .rd_src_rdy_n(a_src_rdy_n), .rd_dst_rdy_n(rd_dst_rdy_n),
        .fifo_status(a_status), .overflow(a_ovf), .frame_cnt(a_cnt)
    );

    udp_tx_frame_fifo #(.FifoAddr(6'd0), .AddrWidth(4), .CntWidth(2)) u_dut_b (
        .udp_tx_rd_clk(clk), .reset_n(rst_b_n),
        .wr_en(wr_en_b), .wr_data(wr_data), .wr_eof(wr_eof), .wr_dst_rdy_n(b_wr_rdy_n),
        .rd_fifo_addr(rd_addr), .rd_sof_n(b_sof_n), .rd_data_out(b_data), .rd_eof_n(b_eof_n),
        .rd_src_rdy_n(b_src_rdy_n), .rd_dst_rdy_n(rd_dst_rdy_n),
        .fifo_status(b_status), .overflow(b_ovf), .frame_cnt(b_cnt)
    );

    assign o_wr_rdy_n  = use_b ? b_wr_rdy_n  : a_wr_rdy_n;
    assign o_sof_n     = use_b ? b_sof_n     : a_sof_n;
    assign o_eof_n     = use_b ? b_eof_n     : a_eof_n;
    assign o_src_rdy_n = use_b ? b_src_rdy_n : a_src_rdy_n;
    assign o_ovf       = use_b ? b_ovf       : a_ovf;
    assign o_data      = use_b ? b_data      : a_data;
    assign o_status    = use_b ? b_status    : a_status;
    assign o_cnt       = use_b ? {2'b00, b_cnt} : a_cnt;

    int ovf_b = 0;
    always @(negedge clk) begin
        if (b_ovf === 1'b1) ovf_b++;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    int span;
    int ovf0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic eof);
        if (use_b) wr_en_b = 1'b1;
        else       wr_en_a = 1'b1;
        wr_data = d;
        wr_eof  = eof;
        tick();
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        wr_eof  = 1'b0;
        wr_data = 8'h00;
    endtask

    task automatic wr_frame(input logic [7:0] start, input logic [7:0] step, input int len);
        for (int i = 0; i < len; i++) wr_byte(start + 8'(i) * step, i == len - 1);
    endtask

    task automatic mk_exp(input logic [7:0] start, input logic [7:0] step, input int len);
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(start + 8'(i) * step);
    endtask

    // mode 0: reader always ready; mode 1: ready on even cycles only
    task automatic rd_frame(input string tag, input int mode, input int budget, output int sp);
        int idx       = 0;
        int first_cyc = 0;
        int last_cyc  = 0;
        for (int cyc = 0; cyc < budget && idx < exp_q.size(); cyc++) begin
            rd_dst_rdy_n = (mode == 1) ? (cyc % 2 == 1) : 1'b0;
            #1;
            if (!o_src_rdy_n) begin
                chk({tag, "_data"}, 32'(o_data), 32'(exp_q[idx]));
                if (!rd_dst_rdy_n) begin
                    chk({tag, "_sof"}, 32'(o_sof_n), (idx == 0) ? 0 : 1);
                    chk({tag, "_eof"}, 32'(o_eof_n), (idx == exp_q.size() - 1) ? 0 : 1);
                    if (idx == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    idx++;
                end
            end
            tick();
        end
        rd_dst_rdy_n = 1'b1;
        chk({tag, "_count"}, idx, exp_q.size());
        sp = last_cyc - first_cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; use_b = 1'b0;
        wr_en_a = 1'b0; wr_en_b = 1'b0; wr_data = 8'h00; wr_eof = 1'b0;
        rd_addr = 6'd0; rd_dst_rdy_n = 1'b1;
        tick();
        chk("rst_wr_rdy_n", 32'(o_wr_rdy_n), 0);
        chk("rst_src_rdy_n", 32'(o_src_rdy_n), 1);
        chk("rst_sof_n", 32'(o_sof_n), 1);
        chk("rst_eof_n", 32'(o_eof_n), 1);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_status", 32'(o_status), 0);
        chk("rst_overflow", 32'(o_ovf), 0);
        chk("rst_frame_cnt", 32'(o_cnt), 0);
        tick();
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick();

        // single frame and write-to-read latency
        wr_frame(8'h11, 8'h11, 3);
        chk("lat_cnt_n1", 32'(o_cnt), 1);
        chk("lat_src_n1", 32'(o_src_rdy_n), 1);
        tick();
        chk("lat_src_n2", 32'(o_src_rdy_n), 1);
        tick();
        chk("lat_src_n3", 32'(o_src_rdy_n), 0);
        chk("lat_sof_n3", 32'(o_sof_n), 0);
        chk("lat_data_n3", 32'(o_data), 32'h11);
        mk_exp(8'h11, 8'h11, 3);
        rd_frame("single", 0, 20, span);
        chk("single_span", span, 2);
        chk("single_cnt_after", 32'(o_cnt), 0);

        // slot select
        rd_addr = 6'd1;
        rd_dst_rdy_n = 1'b0;
        wr_frame(8'h11, 8'h11, 3);
        repeat (5) tick();
        chk("sel_src_rdy_n", 32'(o_src_rdy_n), 1);
        chk("sel_sof_n", 32'(o_sof_n), 1);
        chk("sel_data", 32'(o_data), 0);
        chk("sel_cnt", 32'(o_cnt), 1);
        rd_addr = 6'd0;
        mk_exp(8'h11, 8'h11, 3);
        rd_frame("sel", 0, 20, span);
        chk("sel_span", span, 2);
        chk("sel_cnt_after", 32'(o_cnt), 0);

        // backpressure over a 100-byte frame
        wr_frame(8'h00, 8'h01, 100);
        mk_exp(8'h00, 8'h01, 100);
        rd_frame("bp", 1, 400, span);
        chk("bp_cnt_after", 32'(o_cnt), 0);

        // overflow on the 16-byte instance
        use_b = 1'b1;
        ovf0 = ovf_b;
        wr_frame(8'h40, 8'h01, 20);
        tick(); tick();
        chk("ovf_pulses", ovf_b - ovf0, 1);
        chk("ovf_cnt", 32'(o_cnt), 0);
        chk("ovf_status", 32'(o_status), 0);
        chk("ovf_wr_rdy_n", 32'(o_wr_rdy_n), 0);
        wr_frame(8'hA0, 8'h01, 3);
        tick(); tick(); tick();
        chk("ovf_next_status", 32'(o_status), 3);
        mk_exp(8'hA0, 8'h01, 3);
        rd_frame("ovf_next", 0, 20, span);
        chk("ovf_next_cnt", 32'(o_cnt), 0);

        // frame-count limit
        ovf0 = ovf_b;
        for (int i = 0; i < 4; i++) wr_byte(8'(192 + i), 1'b1);
        tick(); tick();
        chk("lim_cnt", 32'(o_cnt), 3);
        chk("lim_pulses", ovf_b - ovf0, 1);
        chk("lim_wr_rdy_n", 32'(o_wr_rdy_n), 1);
        for (int i = 0; i < 3; i++) begin
            mk_exp(8'(192 + i), 8'h01, 1);
            rd_frame("lim_drain", 0, 20, span);
        end
        chk("lim_cnt_after", 32'(o_cnt), 0);
        chk("lim_wr_rdy_after", 32'(o_wr_rdy_n), 0);

        // 10 x 5-byte frames across pointer wrap, writes overlapping reads
        wr_frame(8'h10, 8'h01, 5);
        for (int f = 0; f < 10; f++) begin
            mk_exp(8'(16 + f * 5), 8'h01, 5);
            fork
                if (f < 9) wr_frame(8'(16 + (f + 1) * 5), 8'h01, 5);
                rd_frame("wrap", 0, 40, span);
            join
            chk("wrap_span", span, 4);
        end
        tick();
        chk("wrap_cnt_after", 32'(o_cnt), 0);
        chk("wrap_status_after", 32'(o_status), 0);

        // reset in the middle of a two-frame backlog
        use_b = 1'b0;
        wr_frame(8'h50, 8'h01, 4);
        wr_frame(8'h60, 8'h01, 4);
        rd_dst_rdy_n = 1'b0;
        for (int i = 0; i < 10 && o_src_rdy_n; i++) tick();
        tick();
        chk("mid_src_rdy_n", 32'(o_src_rdy_n), 0);
        chk("mid_data", 32'(o_data), 32'h51);
        rst_a_n = 1'b0;
        #1;
        chk("mid_rst_src_rdy_n", 32'(o_src_rdy_n), 1);
        chk("mid_rst_sof_n", 32'(o_sof_n), 1);
        chk("mid_rst_eof_n", 32'(o_eof_n), 1);
        chk("mid_rst_data", 32'(o_data), 0);
        chk("mid_rst_cnt", 32'(o_cnt), 0);
        chk("mid_rst_status", 32'(o_status), 0);
        chk("mid_rst_wr_rdy_n", 32'(o_wr_rdy_n), 0);
        chk("mid_rst_overflow", 32'(o_ovf), 0);
        rd_dst_rdy_n = 1'b1;
        tick();
        rst_a_n = 1'b1;
        tick();
        wr_byte(8'hAA, 1'b1);
        mk_exp(8'hAA, 8'h01, 1);
        rd_frame("after_rst", 0, 20, span);
        repeat (4) tick();
        chk("after_rst_cnt", 32'(o_cnt), 0);
        chk("after_rst_idle", 32'(o_src_rdy_n), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/udp_tx_frame_fifo.md
# udp_tx_frame_fifo

- Store-and-forward UDP payload buffer: one frame source, one slot on the UDP reply bus.
- Captures payload bytes from a DCS client (register readback, status replies) into a circular byte buffer.
- Publishes a frame on the local-link read bus only after its last byte is written.
- `udp_reply_mux` selects this slot by `FifoAddr` and drains one frame at a time.

## Interface
Parameters:
- `FifoAddr`, 6'd0: slot address on the read bus; read outputs active only while `rd_fifo_addr == FifoAddr`.
- `AddrWidth`, 11: buffer depth 2^AddrWidth bytes (2048).
- `CntWidth`, 4: width of the committed-frame counter; max 2^CntWidth-1 stored frames.

Ports:
- `udp_tx_rd_clk` in 1: single clock; write and read sides both in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write strobe, one byte per cycle.
- `wr_data` in 8: payload byte.
- `wr_eof` in 1: qualifies `wr_en`; marks the frame's last byte.
- `wr_dst_rdy_n` out 1: 0 = byte can be accepted.
- `rd_fifo_addr` in 6: bus slot select.
- `rd_sof_n` out 1: first byte of frame, active-low.
- `rd_data_out` out 8: frame byte.
- `rd_eof_n` out 1: last byte of frame, active-low.
- `rd_src_rdy_n` out 1: 0 = valid byte presented.
- `rd_dst_rdy_n` in 1: 0 = reader accepts the byte.
- `fifo_status` out 4: occupancy[AddrWidth-1:AddrWidth-4] (committed + uncommitted bytes).
- `overflow` out 1: one-cycle pulse when a frame is dropped.
- `frame_cnt` out CntWidth: committed frames not yet fully read.

## Operation
- **Storage:** RAM 2^AddrWidth x 9 bits, {eof, data}.
- **Pointers:**
  - `wr_ptr`: next write address.
  - `commit_ptr`: start of the frame currently being written.
  - `rd_ptr`: next RAM read address.
  - All AddrWidth bits, wrap modulo depth.
- **Write side:**
  - Accepted write (`wr_en`, not discarding, buffer not full): store {wr_eof, wr_data}, increment `wr_ptr`.
  - On an accepted write with `wr_eof`: `commit_ptr <= wr_ptr+1`, `frame_cnt` +1.
- **Overflow:** `wr_en` while full, or while `frame_cnt` == max and not discarding:
  - `wr_ptr <= commit_ptr` (rollback), `overflow` pulses 1 cycle, enter DISCARD.
  - DISCARD drops all bytes up to and including the next `wr_eof` byte, then returns to normal.
  - No further overflow pulses for the same frame.
- **`wr_dst_rdy_n`:** 1 when full, or when `frame_cnt` == max. Writes are not blocked by it; it is advisory, and overflow handling defines behaviour.
- **Read FSM:**
  - IDLE: `frame_cnt`==0. Outputs idle.
  - LOAD: `frame_cnt`>0. Issue RAM read of `rd_ptr`; next cycle the byte lands in output register `obuf`; `first` flag set; go to PRESENT.
  - PRESENT: `rd_src_rdy_n` = 0 iff slot selected. Transfer = selected & !`rd_src_rdy_n` & !`rd_dst_rdy_n`.
    - Transfer of a non-eof byte: `obuf` refills from RAM (prefetched read), so one byte per cycle is sustained.
    - Transfer of the eof byte: `frame_cnt` −1; go to LOAD if further frames remain, else IDLE.
- **Output values:**
  - `rd_sof_n` = !(`first` & valid); `rd_eof_n` = !(`obuf.eof` & valid).
  - Not selected or not valid: `rd_src_rdy_n`=1, `rd_sof_n`=1, `rd_eof_n`=1, `rd_data_out`=0.
- **Occupancy and full:**
  - Occupancy = `wr_ptr` − `rd_ptr`, counting prefetched bytes as occupied until transferred.
  - Full = occupancy == depth−1.

## Timing
- Reset values: `wr_dst_rdy_n`=0, `rd_src_rdy_n`=1, `rd_sof_n`=1, `rd_eof_n`=1, `rd_data_out`=0, `fifo_status`=0, `overflow`=0, `frame_cnt`=0, FSM IDLE, all pointers 0, DISCARD cleared.
- Write-to-read latency: eof byte written at cycle N → `frame_cnt`=1 at N+1 → `rd_src_rdy_n`=0 at N+3 (LOAD, then RAM read).
- Sustained throughput: 1 byte/cycle while `rd_dst_rdy_n`=0 and the slot is selected.
- Changing `rd_fifo_addr` mid-frame: outputs go idle, state and `obuf` hold, and the frame resumes on reselect. `sof` is not re-asserted.
- Same-cycle eof commit and eof read: `frame_cnt` unchanged.
- Deasserting `rd_dst_rdy_n` (=1) holds `obuf` and all outputs stable.
- Reset asserted mid-frame: all buffered and partial frames are lost; outputs return to reset values asynchronously.

## Test plan
- **Single frame:** write 0x11,0x22,0x33 (eof on 0x33); addr=FifoAddr, dst_rdy_n=0.
  - Read 0x11 (sof_n=0), 0x22, 0x33 (eof_n=0) on consecutive cycles.
  - `frame_cnt` goes 1→0 after 0x33.
- **Slot select:** same frame with rd_fifo_addr=FifoAddr+1.
  - `rd_src_rdy_n` stays 1 and `frame_cnt` stays 1.
  - Switching the address back delivers the full frame.
- **Backpressure:** toggle dst_rdy_n every cycle over a 100-byte frame (0x00..0x63).
  - All 100 bytes are delivered in order, no duplicates.
  - Data is stable while dst_rdy_n=1.
- **Overflow:** AddrWidth=4 (depth 16); write a 20-byte frame.
  - `overflow` pulses once.
  - `frame_cnt`=0 and `fifo_status`=0.
  - A following 3-byte frame is read intact.
- **Frame-count limit and wrap:** CntWidth=2.
  - Write 4 one-byte frames: 4th is dropped with an `overflow` pulse; `frame_cnt`=3.
  - Drain, then write 10 frames of 5 bytes interleaved with reads: all delivered across pointer wrap.
- **Reset:** assert `reset_n`=0 mid-read of a 2-frame backlog.
  - All outputs return to reset values immediately.
  - After release, a new frame 0xAA (eof) is read alone.
